// File: rtl/diag_func_seq_pkg.sv
// diag_func_seq_pkg: shared diag function codes, sequencer states and master-reset macro table
package diag_func_seq_pkg;
  typedef logic [0:6] func_t;
  typedef enum logic [1:0] {IDLE, ARM, STROBE, GAP} state_t;
  localparam int MACRO_LEN = 10;
  localparam func_t FUNC_START = 7'o001;
  localparam func_t FUNC_SET_RESET = 7'o007;
  localparam func_t FUNC_CLR_RESET = 7'o006;
  localparam logic [1:0] STROBE_FALLS = 2'd2;
  localparam logic [1:0] GAP_RISES = 2'd3;
  localparam func_t MACRO_TAB [MACRO_LEN] = '{
    FUNC_SET_RESET, FUNC_CLR_RESET, 7'o000, 7'o044, 7'o046,
    7'o042, 7'o043, 7'o051, 7'o067, 7'o076
  };
endpackage

// File: rtl/diag_func_seq_mhz16_edge.sv
// mhz16_edge: fall/rise detect of MHZ16_FREE on clk (in: clk, CROBAR, MHZ16_FREE; out: fall, rise)
module mhz16_edge (
  input  logic clk,
  input  logic CROBAR,
  input  logic MHZ16_FREE,
  output logic fall,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= CROBAR ? 1'b0 : MHZ16_FREE;
  assign fall = prev & ~MHZ16_FREE;
  assign rise = ~prev & MHZ16_FREE;
endmodule

// File: rtl/diag_func_seq.sv
// diag_func_seq: EBUS diag strobe sequencer for single functions and the master-reset macro
// (in: clk, CROBAR, MHZ16_FREE, reqValid, reqFunc, macroStart; out: reqReady, ds, diagStrobe, busy, done)
module diag_func_seq
  import diag_func_seq_pkg::*;
(
  input  logic       clk,
  input  logic       CROBAR,
  input  logic       MHZ16_FREE,
  input  logic       reqValid,
  input  logic [0:6] reqFunc,
  output logic       reqReady,
  input  logic       macroStart,
  output logic [0:6] ds,
  output logic       diagStrobe,
  output logic       busy,
  output logic       done
);
  state_t state;
  func_t func;
  logic macro;
  logic [3:0] idx;
  logic [1:0] fcnt, rcnt;
  logic fall, rise;
  mhz16_edge u_edge (.clk(clk), .CROBAR(CROBAR), .MHZ16_FREE(MHZ16_FREE), .fall(fall), .rise(rise));
  assign busy = state != IDLE;
  assign reqReady = (state == IDLE) & ~macroStart & ~CROBAR;
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state <= IDLE;
      func <= '0;
      macro <= 1'b0;
      idx <= '0;
      fcnt <= '0;
      rcnt <= '0;
      ds <= '0;
      diagStrobe <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (macroStart) begin
            macro <= 1'b1;
            idx <= '0;
            func <= MACRO_TAB[0];
            state <= ARM;
          end else if (reqValid) begin
            macro <= 1'b0;
            func <= reqFunc;
            state <= ARM;
          end
        ARM:
          if (fall) begin
            ds <= func;
            diagStrobe <= 1'b1;
            fcnt <= '0;
            state <= STROBE;
          end
        STROBE:
          if (fall) begin
            if (fcnt == STROBE_FALLS) begin
              ds <= '0;
              diagStrobe <= 1'b0;
              rcnt <= '0;
              state <= GAP;
            end else fcnt <= fcnt + 2'd1;
          end
        GAP:
          if (rise) begin
            if (rcnt != GAP_RISES) rcnt <= rcnt + 2'd1;
            else if (macro && idx != 4'(MACRO_LEN - 1)) begin
              idx <= idx + 4'd1;
              func <= MACRO_TAB[idx + 4'd1];
              state <= ARM;
            end else begin
              done <= 1'b1;
              state <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_diag_func_seq.sv
// tb_diag_func_seq: randomized scoreboard bench for diag_func_seq
module tb_diag_func_seq;
  logic clk = 0, CROBAR = 1, m16 = 0, reqValid = 0, macroStart = 0;
  logic [0:6] reqFunc = '0;
  logic reqReady, diagStrobe, busy, done;
  logic [0:6] ds;
  logic [0:6] tab [10] = '{7'o007, 7'o006, 7'o000, 7'o044, 7'o046, 7'o042, 7'o043, 7'o051, 7'o067, 7'o076};
  logic [0:6] code_q [$];
  int width_q [$], done_q [$];
  int checks = 0, errors = 0;
  int half = 3, mcnt = 0;
  bit hold = 0, rst_q = 0, in_s = 0;
  int strobes_seen = 0, drops_seen = 0, done_seen = 0, w = 0, exp_w = 0, since_drop = 0;
  logic [0:6] cur = '0;

  diag_func_seq dut (.clk(clk), .CROBAR(CROBAR), .MHZ16_FREE(m16), .reqValid(reqValid), .reqFunc(reqFunc),
    .reqReady(reqReady), .macroStart(macroStart), .ds(ds), .diagStrobe(diagStrobe), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!hold) begin
      if (mcnt >= half - 1) begin
        m16 = ~m16;
        mcnt = 0;
      end else mcnt++;
    end

  always @(posedge clk) rst_q <= CROBAR;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      chk(diagStrobe == 0, "rst_strobe", int'(diagStrobe), 0);
      chk(ds == 0, "rst_ds", int'(ds), 0);
      chk(busy == 0, "rst_busy", int'(busy), 0);
      chk(done == 0, "rst_done", int'(done), 0);
      in_s = 0;
    end else begin
      since_drop++;
      if (diagStrobe && !in_s) begin
        in_s = 1;
        w = 1;
        strobes_seen++;
        chk(busy == 1, "busy_in_strobe", int'(busy), 1);
        if (code_q.size() == 0) begin
          chk(0, "unexpected_strobe", int'(ds), 0);
          cur = ds;
          exp_w = 0;
        end else begin
          cur = code_q.pop_front();
          exp_w = width_q.pop_front();
          chk(ds == cur, "strobe_code", int'(ds), int'(cur));
        end
      end else if (diagStrobe) begin
        w++;
        chk(ds == cur, "ds_stable", int'(ds), int'(cur));
      end else begin
        chk(ds == 0, "ds_zero_no_strobe", int'(ds), 0);
        if (in_s) begin
          in_s = 0;
          drops_seen++;
          since_drop = 0;
          chk(w == exp_w, "strobe_width", w, exp_w);
        end
      end
      if (done) begin
        done_seen++;
        chk(busy == 0, "busy_at_done", int'(busy), 0);
        if (done_q.size() == 0) chk(0, "unexpected_done", 1, 0);
        else begin
          int d;
          d = done_q.pop_front();
          chk(since_drop == d, "done_delay", since_drop, d);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_func(input logic [0:6] c);
    code_q.push_back(c);
    width_q.push_back(6 * half);
  endtask

  task automatic issue_single(input logic [0:6] c);
    push_func(c);
    done_q.push_back(7 * half);
    reqValid = 1;
    reqFunc = c;
    #1 chk(reqReady == 1, "req_ready_idle", int'(reqReady), 1);
    step(1);
    reqValid = 0;
  endtask

  task automatic issue_macro(input bit with_req, input logic [0:6] c);
    foreach (tab[i]) push_func(tab[i]);
    done_q.push_back(7 * half);
    macroStart = 1;
    reqValid = with_req;
    reqFunc = c;
    #1 chk(reqReady == 0, "req_ready_macro", int'(reqReady), 0);
    step(1);
    macroStart = 0;
    reqValid = 0;
  endtask

  task automatic wait_done(input bit chk_busy);
    int target, k;
    target = done_seen + 1;
    k = 0;
    while (done_seen < target && k < 3000) begin
      if (chk_busy && !done) chk(busy == 1, "busy_continuous", int'(busy), 1);
      step(1);
      k++;
    end
    chk(done_seen >= target, "done_timeout", done_seen, target);
    step(1);
  endtask

  task automatic set_half(input int h);
    half = h;
    step(4 * h + 2);
  endtask

  initial begin
    step(1);
    chk(reqReady == 0, "rst_ready", int'(reqReady), 0);
    step(4);
    CROBAR = 0;
    step(3);
    set_half(3);
    issue_single(7'o001);
    wait_done(1);
    chk(reqReady == 1, "ready_after_done", int'(reqReady), 1);
    for (int t = 0; t < 8; t++) begin
      set_half(int'($urandom_range(2, 4)));
      step(int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) issue_macro(0, '0);
      else issue_single(7'($urandom_range(0, 127)));
      wait_done(1);
    end
    set_half(3);
    issue_macro(0, '0);
    wait_done(1);
    issue_macro(1, 7'o044);
    wait_done(1);
    begin
      int base, k, dn;
      base = strobes_seen;
      issue_macro(0, '0);
      k = 0;
      while (strobes_seen < base + 5 && k < 2000) begin
        step(1);
        k++;
      end
      chk(strobes_seen >= base + 5, "fifth_strobe_timeout", strobes_seen, base + 5);
      dn = done_seen;
      CROBAR = 1;
      code_q.delete();
      width_q.delete();
      done_q.delete();
      #1 chk(reqReady == 0, "ready_in_reset", int'(reqReady), 0);
      step(1);
      CROBAR = 0;
      step(60);
      chk(done_seen == dn, "no_done_after_abort", done_seen, dn);
      issue_macro(0, '0);
      wait_done(1);
    end
    hold = 1;
    step(2);
    issue_single(7'o055);
    step(40);
    chk(diagStrobe == 0, "stuck_arm_strobe", int'(diagStrobe), 0);
    chk(busy == 1, "stuck_arm_busy", int'(busy), 1);
    hold = 0;
    wait_done(1);
    begin
      int d0, k;
      d0 = drops_seen;
      issue_single(7'o013);
      k = 0;
      while (drops_seen == d0 && k < 500) begin
        step(1);
        k++;
      end
      chk(drops_seen > d0, "drop_timeout", drops_seen, d0 + 1);
      reqValid = 1;
      reqFunc = 7'o021;
      #1 chk(reqReady == 0, "ready_in_gap", int'(reqReady), 0);
      step(5);
      reqValid = 0;
      wait_done(0);
      chk(reqReady == 1, "ready_after_gap_done", int'(reqReady), 1);
    end
    step(20);
    chk(code_q.size() == 0, "codes_left", code_q.size(), 0);
    chk(done_q.size() == 0, "dones_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
